// File: rtl/nor3_sweep_checker.sv
// Clocked exhaustive sweep of a 3-input NOR gate: drives all eight input vectors,
// samples the gate output at the end of each hold window and tallies mismatches.
module nor3_sweep_checker #(
   parameter int HOLD_CYCLES = 5,
   parameter int ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             y,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [2:0]       fail_vec
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [2:0]        vec;
   logic [HOLD_W-1:0] hold;
   logic              sample;
   logic              mismatch;
   logic              last_vec;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == ERR_MAX) ? v : v + ERR_W'(1);
   endfunction

   function automatic logic nor_ref(input logic [2:0] v);
      return ~|v;
   endfunction

   // vec is forced back to 000 outside DRIVE, so it feeds the gate pins directly
   assign a = vec[2];
   assign b = vec[1];
   assign c = vec[0];

   assign sample   = (state == S_DRIVE) && (hold == HOLD_LAST);
   assign mismatch = sample && (y != nor_ref(vec));
   assign last_vec = (vec == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE:  if (start) state_next = S_DRIVE;
         S_DRIVE: begin
            busy = 1'b1;
            if (sample && last_vec) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec        <= '0;
         hold       <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         pass       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  vec        <= '0;
                  hold       <= '0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  pass       <= 1'b0;
               end
            end
            S_DRIVE: begin
               if (sample) begin
                  if (mismatch) begin
                     err_count <= sat_inc(err_count);
                     if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                     end
                  end
                  hold <= '0;
                  // pass must include the final sample, hence mismatch alongside fail_valid
                  if (last_vec) begin
                     vec  <= '0;
                     pass <= !(fail_valid || mismatch);
                  end else begin
                     vec <= vec + 3'd1;
                  end
               end else begin
                  hold <= hold + HOLD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/nor3_sweep_checker.md
# nor3_sweep_checker

Self-checking stimulus and response stage for the 3-input NOR gate (`norgate`). On a start request it sequences the eight input vectors 000..111 onto the gate's `a`, `b` and `c` inputs, holds each vector for a programmable number of cycles, and samples the gate's `y` output. It compares each sample against the expected NOR value, counts mismatches and records the first failing vector. It sits directly upstream of `norgate` (it drives the inputs) and directly downstream of it (it consumes `y`), replacing the hand-written `#5` stimulus with a synthesizable, clocked sweep.

## Interface
Parameters:
- `HOLD_CYCLES`, default 5: cycles each vector is held; legal range ≥ 1.
- `ERR_W`, default 4: width of the error counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled in IDLE only.
- `y`  in  1  NOR gate output under test.
- `a`  out  1  gate input; vector bit 2 (MSB).
- `b`  out  1  gate input; vector bit 1.
- `c`  out  1  gate input; vector bit 0 (LSB).
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at sweep completion.
- `pass`  out  1  high when the last completed sweep had zero mismatches.
- `err_count`  out  ERR_W  number of mismatches, saturating.
- `fail_valid`  out  1  at least one mismatch seen in the current or last sweep.
- `fail_vec`  out  3  first failing vector {a,b,c}; valid when `fail_valid` is high.

## Operation
- State machine states:
  - IDLE: `a`,`b`,`c` = 000; waits for `start`.
  - DRIVE: holds the current vector; a hold counter runs 0..HOLD_CYCLES-1.
  - DONE: `done` = 1 for one cycle, then returns to IDLE.
- IDLE→DRIVE when `start` = 1. On this transition:
  - vector ← 000, hold counter ← 0;
  - `err_count`, `fail_valid` and `fail_vec` are cleared; `pass` ← 0.
- In DRIVE:
  - `{a,b,c}` = vector, all registered.
  - On the edge where hold counter = HOLD_CYCLES-1, `y` is sampled and compared against expected = ~(a|b|c). Only vector 000 expects 1.
  - On a mismatch: `err_count` increments, saturating at 2^ERR_W-1. If `fail_valid` was 0, `fail_vec` ← vector and `fail_valid` ← 1.
  - After the sample, if vector < 7: vector increments and the hold counter resets. If vector = 7: transition to DONE.
- DONE:
  - `pass` ← (no mismatch in the sweep), computed including the final sample.
  - `a`,`b`,`c` return to 000; `busy` = 0.
- `pass`, `err_count`, `fail_valid` and `fail_vec` hold their values until the next accepted start.
- `start` is ignored in DRIVE and DONE; there is no queuing.
- Reset: asynchronous, any state. All outputs go to 0 and the state goes to IDLE. A sweep in progress is abandoned, with no `done` pulse.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..HOLD_CYCLES drive vector 0, with `busy` = 1 from cycle 1.
- Vector k is driven on cycles 1+k·H .. (k+1)·H, where H = HOLD_CYCLES. `y` is sampled at the rising edge ending cycle (k+1)·H.
- Cycle 8H+1: `done` = 1, `busy` = 0, and `pass` is valid.
- For H = 5, `done` is high in cycle 41; total latency from start to done is 8H+1 cycles.
- `y` is combinational from the registered `a`/`b`/`c` and must settle within one cycle. This makes H = 1 legal.
- `start` held high continuously launches a new sweep in the first IDLE cycle after DONE, i.e. cycle 8H+2.

## Test plan
- Correct `norgate` connected, H = 5, one `start` pulse:
  - required: vectors 000..111 each held for 5 cycles;
  - `done` pulses in cycle 41;
  - `pass` = 1, `err_count` = 0, `fail_valid` = 0.
- `y` tied to 0:
  - required: `err_count` = 1, `fail_vec` = 000, `fail_valid` = 1, `pass` = 0.
- `y` tied to 1:
  - required: `err_count` = 7, `fail_vec` = 001, `pass` = 0.
- `y` = a|b|c (inverted gate), ERR_W = 2:
  - required: `err_count` saturates at 3;
  - `fail_vec` = 000, `pass` = 0.
- `start` pulsed again during vector 3, then `rst_n` pulsed low during vector 5 of a fresh sweep:
  - required: the second start is ignored and the first sweep completes normally.
  - On the reset, all outputs are 0 asynchronously and no `done` pulse occurs.
  - A following `start` runs a clean sweep with `pass` = 1.
- H = 1, `start` held high:
  - required: `done` in cycle 9;
  - the next sweep begins in cycle 10, with `err_count` cleared at that accept.
